// File: rtl/unary_binary_mac.sv
// Unary-stream multiply-accumulate: out = a*b + c, one unary bit per cycle.
// Optional macro UNARY_EARLY_DONE_EN ends the stream as soon as a_reg is reached.
module unary_binary_mac #(
    parameter int SIZE = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    input  logic [SIZE-1:0]   c,
    output logic              ready,
    output logic [2*SIZE-1:0] out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [SIZE-1:0] LAST = '1;

    state_t            state;
    state_t            next_state;
    logic [SIZE-1:0]   a_reg;
    logic [SIZE-1:0]   b_reg;
    logic [SIZE-1:0]   c_reg;
    logic [SIZE-1:0]   counter_out;
    logic              unary;
    logic [2*SIZE-1:0] unary_out;
    logic [2*SIZE-1:0] acc;
    logic              start;
    logic              finish;

    assign unary     = (counter_out < a_reg);
    assign unary_out = unary ? {{SIZE{1'b0}}, b_reg} : '0;
    assign out       = acc;

`ifdef UNARY_EARLY_DONE_EN
    // Past a_reg the stream is all zeros, so stopping there loses nothing.
    assign finish = (counter_out == a_reg);
`else
    assign finish = (counter_out == LAST);
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a new request is only accepted outside BUSY.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (valid) begin
                    start      = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (finish) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, unary counter and accumulator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            c_reg       <= '0;
            counter_out <= '0;
            acc         <= '0;
            ready       <= 1'b0;
        end else if (start) begin
            a_reg       <= a;
            b_reg       <= b;
            c_reg       <= c;
            counter_out <= '0;
            acc         <= {{SIZE{1'b0}}, c};
            ready       <= 1'b0;
        end else if (state == BUSY) begin
            if (finish) begin
                ready <= 1'b1;
            end else begin
                acc         <= acc + unary_out;
                counter_out <= counter_out + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_unary_binary_mac.sv
// Directed bench for unary_binary_mac at SIZE=3.
// Honours UNARY_EARLY_DONE_EN when computing expected latency.
module tb_unary_binary_mac;

    localparam int SIZE = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              valid = 1'b0;
    logic [SIZE-1:0]   a = '0;
    logic [SIZE-1:0]   b = '0;
    logic [SIZE-1:0]   c = '0;
    logic              ready;
    logic [2*SIZE-1:0] out;

    int total = 0;
    int bad = 0;
    int edges;

    unary_binary_mac #(.SIZE(SIZE)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .valid(valid),
        .a(a),
        .b(b),
        .c(c),
        .ready(ready),
        .out(out)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int lat(input int av);
`ifdef UNARY_EARLY_DONE_EN
        return av + 1;
`else
        return 8;
`endif
    endfunction

    // Present one request, capture it, and count edges until ready.
    task automatic run(input int av, input int bv, input int cv,
                       input bit inject, output int n);
        @(negedge clk);
        valid = 1'b1;
        a = av[SIZE-1:0];
        b = bv[SIZE-1:0];
        c = cv[SIZE-1:0];
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("ready_clear_on_capture", int'(ready), 0);
        n = 0;
        while (n < 20) begin
            if (inject && n == 1) begin
                valid = 1'b1;
                a = 3'd7;
                b = 3'd7;
                c = 3'd7;
            end
            if (inject && n == 2) begin
                valid = 1'b0;
            end
            @(posedge clk);
            n++;
            #1;
            if (ready) break;
        end
    endtask

    initial begin
        #12;
        chk("reset_ready", int'(ready), 0);
        chk("reset_out", int'(out), 0);
        chk("reset_a_reg", int'(dut.a_reg), 0);
        chk("reset_counter", int'(dut.counter_out), 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ready", int'(ready), 0);

        run(7, 7, 7, 1'b0, edges);
        chk("max_latency", edges, lat(7));
        chk("max_out", int'(out), 56);
        repeat (3) @(posedge clk);
        #1;
        chk("max_hold_ready", int'(ready), 1);
        chk("max_hold_out", int'(out), 56);

        run(3, 2, 1, 1'b0, edges);
        chk("a3b2c1_latency", edges, lat(3));
        chk("a3b2c1_out", int'(out), 7);

        run(0, 5, 3, 1'b0, edges);
        chk("a0_latency", edges, lat(0));
        chk("a0_out", int'(out), 3);

        run(5, 0, 6, 1'b0, edges);
        chk("b0_latency", edges, lat(5));
        chk("b0_out", int'(out), 6);

        run(2, 3, 0, 1'b1, edges);
        chk("ignore_latency", edges, lat(2));
        chk("ignore_out", int'(out), 6);
        chk("ignore_a_reg", int'(dut.a_reg), 2);

        @(negedge clk);
        valid = 1'b1;
        a = 3'd7;
        b = 3'd7;
        c = 3'd7;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_ready", int'(ready), 0);
        chk("abort_out", int'(out), 0);
        chk("abort_counter", int'(dut.counter_out), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_reset_idle_ready", int'(ready), 0);
        chk("post_reset_idle_out", int'(out), 0);

        run(1, 1, 1, 1'b0, edges);
        chk("after_reset_latency", edges, lat(1));
        chk("after_reset_out", int'(out), 2);

        run(4, 4, 0, 1'b0, edges);
        chk("b2b_latency", edges, lat(4));
        chk("b2b_out", int'(out), 16);

        run(2, 5, 1, 1'b0, edges);
        chk("a2b5c1_latency", edges, lat(2));
        chk("a2b5c1_out", int'(out), 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unary_binary_mac.md
UNARY_BINARY_MAC -- requirements
Module: unary_binary_MAC

Interface
REQ-001 SHALL have parameter SIZE, default 3, the operand width in bits (SIZE >= 2).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port valid, input, 1 bit: request to start an operation with the current a, b, c.
REQ-005 SHALL have ports a, b, c, input, SIZE bits each: unsigned multiplicand, multiplier, addend.
REQ-006 SHALL have port ready, output, 1 bit: high while out holds a completed result.
REQ-007 SHALL have port out, output, 2*SIZE bits: unsigned result a*b+c.
REQ-008 SHALL expose the following internal signals by these exact names for bench probing:
- a_reg, b_reg, c_reg: captured operands.
- counter_out: SIZE-bit cycle counter.
- unary: 1-bit stream, equal to (counter_out < a_reg).
- unary_out: 2*SIZE bits, equal to b_reg when unary is 1, else 0.

Function
REQ-009 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-010 SHALL, in IDLE or DONE with valid=1 at a rising edge:
- capture a, b, c into a_reg, b_reg, c_reg;
- clear counter_out to 0;
- load the accumulator (driving out) with zero-extended c;
- clear ready;
- enter BUSY.
REQ-011 SHALL, in each BUSY cycle, add unary_out to the accumulator and increment counter_out by 1.
REQ-012 SHALL leave BUSY on the cycle where counter_out equals 2^SIZE-1: no add on that cycle (unary is 0), enter DONE, set ready=1.
REQ-013 SHALL therefore assert ready exactly 2^SIZE rising edges after the capture edge, independent of operand values (8 cycles for SIZE=3).
REQ-014 SHALL hold out and ready=1 in DONE until a new valid is captured or reset occurs.
REQ-015 SHALL ignore valid while BUSY, with no effect on operands or timing.
REQ-016 SHALL drive out from the accumulator register at all times; out is meaningful only while ready=1.
REQ-017 SHALL produce an exact, non-overflowing result: max (2^SIZE-1)^2 + (2^SIZE-1) < 2^(2*SIZE).
REQ-018 SHALL handle a_reg=0 by leaving out=c (no additions); b_reg=0 likewise yields out=c.

Reset
REQ-019 SHALL, when reset_n=0, immediately force:
- state to IDLE;
- ready, out, a_reg, b_reg, c_reg, counter_out to 0.
REQ-020 SHALL abort any in-progress operation on reset with no result delivered; after release, the block waits in IDLE for valid.

Configuration
REQ-021 SHALL support macro UNARY_EARLY_DONE_EN.
- Defined: BUSY exits on the cycle where counter_out equals a_reg (no add that cycle), so ready asserts a_reg+1 edges after capture.
- Not defined: fixed latency per REQ-012/REQ-013.
- Results are identical in both modes.

Verification (SIZE=3)
REQ-022 a=7, b=7, c=7, valid pulsed for one cycle -> ready=1 exactly 8 edges after capture, out=56; ready and out hold while valid stays 0.
REQ-023 a=3, b=2, c=1 -> out=7; a=0, b=5, c=3 -> out=3; a=5, b=0, c=6 -> out=6.
REQ-024 Start a=2, b=3, c=0, then present valid with a=7 mid-BUSY -> out=6 at the normal 8-cycle time; the second request is ignored.
REQ-025 reset_n pulsed low mid-BUSY -> ready=0 and out=0 immediately; the next valid with a=1, b=1, c=1 -> out=2.
REQ-026 Back-to-back: valid asserted in DONE with a=4, b=4, c=0 -> ready drops next cycle, out=16 after 8 cycles.
REQ-027 With UNARY_EARLY_DONE_EN defined: a=2, b=5, c=1 -> ready 3 edges after capture, out=11; a=7, b=7, c=7 -> ready after 8 edges, out=56.
